fdivsqrt_iter_ctrl: RTL and testbench

- Sequencing controller for the radix-4 divide/square-root iteration datapath, which uses carry-save residual, digit selection and on-the-fly conversion.
- Accepts a start request from the execute stage and loads the datapath.
- Enables exactly N residual iterations, flags the first sqrt iteration to the digit-selection logic (j1), then holds a done handshake until the memory stage accepts the result.
- Handles special-case early completion and pipeline flush.

---
 rtl/fdivsqrt_iter_ctrl.sv | 99 +++++++++
 tb/tb_fdivsqrt_iter_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/fdivsqrt_iter_ctrl.sv
// Sequencing controller for the radix-4 divide/sqrt iteration datapath:
// start/load, N residual iterations with j1 flag, done handshake, flush.
module fdivsqrt_iter_ctrl #(
    parameter int unsigned CW = 7
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          FDivStartE,
    input  logic          SqrtE,
    input  logic          SpecialCaseE,
    input  logic [CW-1:0] Cycles,
    input  logic          FlushE,
    input  logic          StallM,
    output logic          IFDivStartE,
    output logic          IterEn,
    output logic          j1,
    output logic          SqrtOp,
    output logic [CW-1:0] Step,
    output logic          FDivBusyE,
    output logic          FDivDoneE
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        state, state_n;
    logic [CW-1:0] step_n;
    logic          j1_n;
    logic          sqrt_n;

    // State and operation registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state  <= IDLE;
            Step   <= '0;
            j1     <= 1'b0;
            SqrtOp <= 1'b0;
        end else begin
            state  <= state_n;
            Step   <= step_n;
            j1     <= j1_n;
            SqrtOp <= sqrt_n;
        end
    end

    // Next-state and handshake decode
    always_comb begin
        state_n     = state;
        step_n      = Step;
        j1_n        = 1'b0;
        sqrt_n      = SqrtOp;
        IFDivStartE = (state == IDLE) & FDivStartE & ~FlushE;
        IterEn      = (state == BUSY);
        FDivDoneE   = (state == DONE);
        FDivBusyE   = (state == BUSY) | (IFDivStartE & ~SpecialCaseE);

        case (state)
            IDLE: begin
                if (IFDivStartE) begin
                    sqrt_n = SqrtE;
                    if (SpecialCaseE) begin
                        state_n = DONE;
                    end else begin
                        state_n = BUSY;
                        step_n  = (Cycles == '0) ? CW'(1) : Cycles;
                        j1_n    = SqrtE;
                    end
                end
            end
            BUSY: begin
                if (FlushE) begin
                    state_n = IDLE;
                    step_n  = '0;
                    sqrt_n  = 1'b0;
                end else begin
                    // Saturate at zero; Step==1 marks the final iteration
                    step_n = (Step == '0) ? '0 : Step - CW'(1);
                    if (Step <= CW'(1)) begin
                        state_n = DONE;
                    end
                end
            end
            DONE: begin
                if (FlushE) begin
                    state_n = IDLE;
                    step_n  = '0;
                    sqrt_n  = 1'b0;
                end else if (!StallM) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
                step_n  = '0;
                sqrt_n  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_fdivsqrt_iter_ctrl.sv
// Self-checking bench for fdivsqrt_iter_ctrl: directed scenarios plus random
// traffic against an operation-level reference model.
module tb_fdivsqrt_iter_ctrl;

    localparam int unsigned CW = 7;
    localparam int unsigned VW = CW + 6;

    logic          clk = 1'b0;
    logic          resetn;
    logic          FDivStartE, SqrtE, SpecialCaseE, FlushE, StallM;
    logic [CW-1:0] Cycles;
    logic          IFDivStartE, IterEn, j1, SqrtOp, FDivBusyE, FDivDoneE;
    logic [CW-1:0] Step;

    int errors = 0;
    int checks = 0;

    // Reference model: iterations remaining, result-pending flag, first-iteration flag
    int m_left;
    bit m_done, m_first, m_sqrt;

    // Observed activity counters for per-operation totals
    int n_iter, n_done, n_j1, n_busy;

    fdivsqrt_iter_ctrl #(.CW(CW)) dut (
        .clk(clk), .resetn(resetn), .FDivStartE(FDivStartE), .SqrtE(SqrtE),
        .SpecialCaseE(SpecialCaseE), .Cycles(Cycles), .FlushE(FlushE),
        .StallM(StallM), .IFDivStartE(IFDivStartE), .IterEn(IterEn), .j1(j1),
        .SqrtOp(SqrtOp), .Step(Step), .FDivBusyE(FDivBusyE), .FDivDoneE(FDivDoneE)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clr_counts();
        n_iter = 0; n_done = 0; n_j1 = 0; n_busy = 0;
    endtask

    function automatic logic [VW-1:0] dut_vec();
        return {IFDivStartE, IterEn, j1, SqrtOp, FDivBusyE, FDivDoneE, Step};
    endfunction

    // One clock cycle: drive inputs, check outputs at negedge, advance model at posedge
    task automatic cyc(input bit st, input bit sq, input bit sp, input int cy,
                       input bit fl, input bit stl);
        bit idle, e_start, e_iter;
        logic [VW-1:0] exp_v, obs_v;
        int n;
        FDivStartE = st; SqrtE = sq; SpecialCaseE = sp; Cycles = CW'(cy);
        FlushE = fl; StallM = stl;
        @(negedge clk);
        idle    = !m_done && (m_left == 0);
        e_start = idle && st && !fl && resetn;
        e_iter  = (m_left > 0);
        exp_v = {e_start, e_iter, e_iter && m_first && m_sqrt, m_sqrt,
                 e_iter || (e_start && !sp), m_done, CW'(m_left)};
        obs_v = dut_vec();
        checks++;
        assert (obs_v === exp_v) else begin
            errors++;
            $error("FAIL outputs t=%0t observed=%h expected=%h (start,iter,j1,sqrt,busy,done,step)",
                   $time, obs_v, exp_v);
        end
        checks++;
        assert ($onehot0({IFDivStartE, IterEn, FDivDoneE})) else begin
            errors++;
            $error("FAIL exclusive t=%0t observed=%b expected=onehot0",
                   $time, {IFDivStartE, IterEn, FDivDoneE});
        end
        n_iter += int'(IterEn); n_done += int'(FDivDoneE);
        n_j1 += int'(j1); n_busy += int'(FDivBusyE);
        @(posedge clk);
        if (!resetn) begin
            m_left = 0; m_done = 0; m_first = 0; m_sqrt = 0;
        end else if (fl && !idle) begin
            m_left = 0; m_done = 0; m_first = 0; m_sqrt = 0;
        end else if (idle) begin
            if (e_start) begin
                m_sqrt = sq;
                if (sp) m_done = 1;
                else begin
                    n = cy % (1 << CW);
                    m_left = (n == 0) ? 1 : n;
                    m_first = 1;
                end
            end
        end else if (m_left > 0) begin
            m_left--;
            m_first = 0;
            if (m_left == 0) m_done = 1;
        end else if (!stl) begin
            m_done = 0;
        end
        #1;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        resetn = 1'b0;
        m_left = 0; m_done = 0; m_first = 0; m_sqrt = 0;
        clr_counts();
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("reset_vec", int'(dut_vec()), 0);
        resetn = 1'b1;
        idle_cycles(2);

        // Divide, 14 iterations
        clr_counts();
        cyc(1, 0, 0, 14, 0, 0);
        idle_cycles(16);
        chk("div14_iters", n_iter, 14);
        chk("div14_done", n_done, 1);
        chk("div14_j1", n_j1, 0);

        // Sqrt, 13 iterations
        clr_counts();
        cyc(1, 1, 0, 13, 0, 0);
        chk("sqrt_j1_first", int'(j1), 1);
        idle_cycles(15);
        chk("sqrt13_iters", n_iter, 13);
        chk("sqrt13_j1", n_j1, 1);
        chk("sqrt13_done", n_done, 1);

        // Special case completes without iterating
        clr_counts();
        cyc(1, 0, 1, 20, 0, 0);
        idle_cycles(3);
        chk("spec_iters", n_iter, 0);
        chk("spec_busy", n_busy, 0);
        chk("spec_done", n_done, 1);

        // Stalled done, start in DONE ignored, start after IDLE accepted
        clr_counts();
        cyc(1, 0, 0, 5, 0, 0);
        idle_cycles(5);
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 9, 0, 1);
        cyc(1, 0, 0, 9, 0, 0);
        chk("stall_done", n_done, 4);
        cyc(1, 0, 0, 3, 0, 0);
        chk("restart_step", int'(Step), 3);
        idle_cycles(5);
        chk("stall_iters", n_iter, 8);

        // Flush on the third BUSY cycle, then an immediate 2-iteration op
        clr_counts();
        cyc(1, 1, 0, 10, 0, 0);
        idle_cycles(2);
        cyc(0, 0, 0, 0, 1, 0);
        chk("flush_step", int'(Step), 0);
        chk("flush_nodone", n_done, 0);
        cyc(1, 0, 0, 2, 0, 0);
        idle_cycles(2);
        chk("after_flush_done", int'(FDivDoneE), 1);
        idle_cycles(2);

        // Asynchronous reset with Step=7
        cyc(1, 1, 0, 10, 0, 0);
        idle_cycles(3);
        chk("pre_rst_step", int'(Step), 7);
        resetn = 1'b0;
        #1;
        chk("async_rst", int'(dut_vec()), 0);
        m_left = 0; m_done = 0; m_first = 0; m_sqrt = 0;
        @(posedge clk);
        #1;
        resetn = 1'b1;

        // Cycles=0 treated as one iteration
        clr_counts();
        cyc(1, 0, 0, 0, 0, 0);
        idle_cycles(3);
        chk("cyc0_iters", n_iter, 1);
        chk("cyc0_done", n_done, 1);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            int cy;
            cy = ($urandom % 20 == 0) ? int'($urandom % 128) : int'($urandom % 8);
            cyc(($urandom % 3) == 0, $urandom % 2 == 1, ($urandom % 6) == 0, cy,
                ($urandom % 15) == 0, $urandom % 2 == 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
